// File: rtl/generic_fifo_stream_reader.sv
// Drains a non-show-ahead FIFO read port into a valid/ready stream through a
// 3-entry buffer, framing fixed-length packets and counting delivered words.
module generic_fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_empty_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [31:0]           words_o,
  output logic                  idle_o
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] PKT_MAX = CW'(PKT_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           words_q, words_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];

  logic       pop;
  logic [1:0] wr_idx;
  logic [2:0] occ_sum;

  // Stream handshake: a word transfers on any rising clock edge where
  // valid_o && ready_i. valid_o never waits on ready_i, and while valid_o is
  // high without ready_i the word, its last_o flag and valid_o stay stable.
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = buf_q[0];
  assign last_o  = valid_o && (pkt_cnt_q == PKT_MAX);
  assign words_o = words_q;
  assign idle_o  = (occ_q == 2'd0) && !inflight_q;

  always_comb begin
    fifo_rd_o  = enable_i && !fifo_empty_i && !rst_i &&
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
    pop        = valid_o && ready_i;
    occ_sum    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    occ_d      = occ_sum[1:0];
    inflight_d = fifo_rd_o;

    // Head is slot 0. A pop of the only word leaves slot 0 untouched so
    // data_o keeps showing the last word while the buffer is empty.
    buf_d = buf_q;
    if (pop && (occ_q > 2'd1)) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
    end
    wr_idx = occ_q - {1'b0, pop};
    if (inflight_q) begin
      case (wr_idx)
        2'd0:    buf_d[0] = fifo_q_i;
        2'd1:    buf_d[1] = fifo_q_i;
        default: buf_d[2] = fifo_q_i;
      endcase
    end

    pkt_cnt_d = pkt_cnt_q;
    if (pop) begin
      pkt_cnt_d = (pkt_cnt_q == PKT_MAX) ? '0 : pkt_cnt_q + CW'(1);
    end
    words_d = words_q + 32'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      pkt_cnt_q  <= '0;
      words_q    <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      pkt_cnt_q  <= pkt_cnt_d;
      words_q    <= words_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

  // The read gate keeps occupancy plus in-flight at or below three.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (occ_sum <= 3'd3);
    end
  end

endmodule

// File: tb/tb_generic_fifo_stream_reader.sv
// Bench for generic_fifo_stream_reader: FIFO model, queue-based output model,
// per-cycle comparison and directed scenarios with literal expectations.
module tb_generic_fifo_stream_reader;

  localparam int DW        = 16;
  localparam int PKT       = 16;
  localparam int MEM_DEPTH = 2048;

  logic          clk      = 1'b0;
  logic          rst_i    = 1'b1;
  logic          enable_i = 1'b0;
  logic          ready_i  = 1'b0;
  logic [DW-1:0] fifo_q_i = '0;
  logic          fifo_empty_i;
  logic          fifo_rd_o, valid_o, last_o, idle_o;
  logic [DW-1:0] data_o;
  logic [31:0]   words_o;
  logic          p1_rd, p1_valid, p1_last, p1_idle;
  logic [DW-1:0] p1_data;
  logic [31:0]   p1_words;

  logic [DW-1:0] fifo_mem [MEM_DEPTH];
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  // Output model: exp_q holds words read from the FIFO and captured, in order.
  logic [DW-1:0] exp_q[$];
  logic          m_inflight  = 1'b0;
  logic [DW-1:0] m_pend      = '0;
  logic [DW-1:0] m_last_data = '0;
  int            m_pkt       = 0;
  logic [31:0]   m_words     = '0;
  logic [31:0]   words_base  = '0;

  generic_fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .fifo_rd_o(fifo_rd_o),
    .fifo_q_i(fifo_q_i), .fifo_empty_i(fifo_empty_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .words_o(words_o),
    .idle_o(idle_o)
  );

  generic_fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut_p1 (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .fifo_rd_o(p1_rd),
    .fifo_q_i(fifo_q_i), .fifo_empty_i(fifo_empty_i), .valid_o(p1_valid),
    .ready_i(ready_i), .data_o(p1_data), .last_o(p1_last), .words_o(p1_words),
    .idle_o(p1_idle)
  );

  // Clock
  always #5 clk = ~clk;

  // Non-show-ahead FIFO: q presents the popped word the cycle after rd.
  assign fifo_empty_i = (rd_cnt == wr_cnt);
  always @(posedge clk) begin
    if (fifo_rd_o && !fifo_empty_i) begin
      fifo_q_i <= fifo_mem[rd_cnt];
      rd_cnt   <= rd_cnt + 1;
    end else begin
      fifo_q_i <= DW'($urandom);
    end
  end

  function automatic logic model_rd();
    return enable_i && !fifo_empty_i && !rst_i &&
           ((exp_q.size() + int'(m_inflight)) < 3);
  endfunction

  always @(posedge clk or posedge rst_i) begin
    logic rd_now;
    if (rst_i) begin
      exp_q.delete();
      m_inflight  = 1'b0;
      m_pkt       = 0;
      m_words     = '0;
      m_last_data = '0;
    end else begin
      rd_now = model_rd();
      if ((exp_q.size() != 0) && ready_i) begin
        m_last_data = exp_q.pop_front();
        m_words     = m_words + 32'd1;
        m_pkt       = (m_pkt == PKT - 1) ? 0 : m_pkt + 1;
      end
      if (m_inflight) exp_q.push_back(m_pend);
      m_inflight = rd_now;
      m_pend     = fifo_mem[rd_cnt];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic          ev;
    logic [DW-1:0] ed;
    ev = (exp_q.size() != 0);
    ed = m_last_data;
    if (ev) ed = exp_q[0];
    check("fifo_rd", fifo_rd_o, model_rd());
    check("valid", valid_o, ev);
    check("data", data_o, ed);
    check("last", last_o, ev && (m_pkt == PKT - 1));
    check("words", words_o, m_words + words_base);
    check("idle", idle_o, !ev && !m_inflight);
    check("p1_fifo_rd", p1_rd, model_rd());
    check("p1_valid", p1_valid, ev);
    check("p1_data", p1_data, ed);
    check("p1_last", p1_last, ev);
    check("p1_words", p1_words, m_words);
    check("p1_idle", p1_idle, !ev && !m_inflight);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    if (wr_cnt < MEM_DEPTH) begin
      fifo_mem[wr_cnt] = w;
      wr_cnt++;
    end
  endtask

  initial begin
    int            first_rd, first_v, t_first, t_last, reads0;
    logic          got;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];

    // Reset with the FIFO already holding words
    enable_i = 1'b1;
    ready_i  = 1'b1;
    for (int i = 1; i <= 64; i++) push_word(DW'(i));
    repeat (4) step();
    check("rst_fifo_rd", fifo_rd_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    check("rst_words", words_o, 0);
    check("rst_idle", idle_o, 1);

    // Streaming 0x0001..0x0040 with ready held high
    rst_i = 1'b0;
    #1;
    first_rd = -1;
    first_v  = -1;
    t_first  = -1;
    t_last   = -1;
    for (int cyc = 0; cyc < 200 && got_d.size() < 64; cyc++) begin
      if (fifo_rd_o && first_rd < 0) first_rd = cyc;
      if (valid_o && first_v < 0) first_v = cyc;
      if (valid_o && ready_i) begin
        if (got_d.size() == 0) t_first = cyc;
        t_last = cyc;
        got_d.push_back(data_o);
        got_l.push_back(last_o);
      end
      step();
    end
    check("first_rd_cycle", first_rd, 0);
    check("first_latency", first_v - first_rd, 2);
    check("stream_count", got_d.size(), 64);
    for (int i = 0; i < got_d.size(); i++) begin
      check("stream_data", got_d[i], i + 1);
      check("stream_last", got_l[i], ((i + 1) % 16) == 0);
    end
    check("stream_rate", t_last - t_first, 63);
    check("stream_words", words_o, 64);

    // Backpressure: ready low with plenty in the FIFO
    ready_i = 1'b0;
    for (int i = 0; i < 40; i++) push_word(DW'($urandom));
    reads0 = rd_cnt;
    repeat (10) step();
    check("bp_reads", rd_cnt - reads0, 3);
    check("bp_rd_low", fifo_rd_o, 0);
    check("bp_occ", dut.occ_q, 3);

    // Word counter wrap
    words_base = 32'hFFFF_FFFE - m_words;
    force dut.words_q = 32'hFFFF_FFFE;
    step();
    release dut.words_q;
    ready_i = 1'b1;
    step();
    check("wrap_0", words_o, 32'hFFFF_FFFF);
    step();
    check("wrap_1", words_o, 32'h0000_0000);
    step();
    check("wrap_2", words_o, 32'h0000_0001);

    // Random ready and enable over 1000 words
    for (int i = 0; i < 1000; i++) push_word(DW'($urandom));
    for (int cyc = 0; cyc < 8000 && !(fifo_empty_i && idle_o); cyc++) begin
      ready_i  = ($urandom_range(0, 3) != 0);
      enable_i = ($urandom_range(0, 7) != 0);
      step();
    end
    enable_i = 1'b1;
    check("rand_drained", rd_cnt, wr_cnt);
    check("rand_idle", idle_o, 1);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_p1_words", p1_words, 1104);
    check("rand_words", words_o, 1038);

    // Enable dropped one cycle after a read
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) push_word(DW'(16'h0100 + i));
    reads0 = rd_cnt;
    step();
    enable_i = 1'b0;
    repeat (3) step();
    check("en_reads", rd_cnt - reads0, 1);
    check("en_rd_low", fifo_rd_o, 0);
    ready_i = 1'b1;
    repeat (4) step();
    check("en_idle", idle_o, 1);
    check("en_p1_words", p1_words, 1105);

    // Reset with two words buffered and one in flight
    ready_i  = 1'b0;
    enable_i = 1'b1;
    repeat (3) step();
    check("mid_occ", dut.occ_q, 2);
    check("mid_inflight", dut.inflight_q, 1);
    words_base = '0;
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_words", words_o, 0);
    check("mid_rst_p1_words", p1_words, 0);
    check("mid_rst_rd", fifo_rd_o, 0);
    repeat (2) step();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    #1;
    got = 1'b0;
    for (int cyc = 0; cyc < 20 && !got; cyc++) begin
      if (valid_o && ready_i) begin
        got = 1'b1;
        check("post_rst_data", data_o, 16'h0104);
        check("post_rst_last16", last_o, 0);
        check("post_rst_last1", p1_last, 1);
      end
      step();
    end
    check("post_rst_seen", got, 1);
    for (int cyc = 0; cyc < 100 && !(fifo_empty_i && idle_o); cyc++) step();
    check("final_words", words_o, 6);
    check("final_p1_words", p1_words, 6);
    check("final_idle", idle_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/generic_fifo_stream_reader.md
# generic_fifo_stream_reader

Single-clock read-side adapter that drains the read port of a `generic_async_fifo` instance (non-show-ahead, `q` valid one cycle after `rd`) and presents words as a valid/ready stream. It sits in the FIFO read clock domain. A 3-entry output buffer gives full throughput with no combinational path from `ready_i` to the FIFO read strobe. It also frames the stream into fixed-length packets (`last_o`) and counts delivered words.

## Interface
- `DATA_WIDTH`, default 16: FIFO and stream word width.
- `PKT_LEN`, default 256: words per packet; `last_o` marks every `PKT_LEN`-th word. Legal range is ≥1.

Ports:
- `clk_i`  in  1  Single clock (FIFO read clock).
- `rst_i`  in  1  Reset. Asynchronous, active-high.
- `enable_i`  in  1  High: new FIFO reads may be issued. Low: no new reads; buffered and in-flight words still drain.
- `fifo_rd_o`  out  1  Read strobe to the FIFO `rd_i`.
- `fifo_q_i`  in  DATA_WIDTH  FIFO `q_o`; valid in the cycle after `fifo_rd_o` was high.
- `fifo_empty_i`  in  1  FIFO `rd_empty_o`.
- `valid_o`  out  1  Stream word valid.
- `ready_i`  in  1  Stream consumer ready.
- `data_o`  out  DATA_WIDTH  Stream word (buffer head).
- `last_o`  out  1  Final word of the packet; qualified by `valid_o`.
- `words_o`  out  32  Count of accepted words (`valid_o && ready_i`). Wraps modulo 2^32.
- `idle_o`  out  1  High when the buffer is empty and no read is in flight.

## Operation
- State:
  - `occ` (0..3) is the buffer occupancy.
  - `inflight` (0/1) is registered `fifo_rd_o` from the previous cycle.
  - `pkt_cnt` runs 0..PKT_LEN-1.
  - `words` is the 32-bit accepted-word counter.
- `fifo_rd_o = enable_i && !fifo_empty_i && (occ + inflight < 3) && !rst_i`. It depends only on registered state and these inputs, never on `ready_i`.
- Capture: when `inflight`=1, `fifo_q_i` is written to the buffer tail at the clock edge.
- Pop: when `valid_o && ready_i`, the head is removed at the clock edge.
- Occupancy update: `occ_next = occ + inflight - pop`. A simultaneous capture and pop leaves `occ` unchanged and preserves order. Overflow is impossible by construction; reaching `occ` > 3 is a design error (assertion).
- `valid_o = (occ != 0)`. `data_o` is the head entry. When `occ`=0, `data_o` holds its last value (0 after reset).
- `last_o = valid_o && (pkt_cnt == PKT_LEN-1)`. `pkt_cnt` increments on each pop and wraps to 0 after the word carrying `last_o`. With `PKT_LEN`=1, `last_o` equals `valid_o`.
- `words_o` increments by 1 on each pop.
- `idle_o = (occ == 0) && !inflight`.
- Clearing `enable_i` does not abort an in-flight read; that word is still captured and delivered.
- Packet framing is independent of `enable_i`. `pkt_cnt` is never cleared except by reset.

## Timing
- Reset values while `rst_i` is high:
  - `fifo_rd_o`=0, `valid_o`=0, `data_o`=0, `last_o`=0, `words_o`=0, `idle_o`=1.
  - `occ`=0, `inflight`=0, `pkt_cnt`=0.
- Reset asserted mid-operation: buffered and in-flight words are discarded. After release, `pkt_cnt` restarts at 0. The paired FIFO is expected to be reset by the same `rst_i`.
- First-word latency: `fifo_rd_o` high in cycle n → `valid_o` high in cycle n+2 with that word.
- Throughput: with `ready_i` held high and the FIFO non-empty, the stream carries one word per cycle in steady state (`occ`=1, `inflight`=1).
- Backpressure: with `ready_i` low, at most 3 words are buffered. `fifo_rd_o` stops once `occ + inflight` = 3. No data is lost or duplicated.
- `valid_o`/`data_o`/`last_o` hold stable while `valid_o && !ready_i`.
- FIFO empties mid-burst: `fifo_rd_o` drops in the same cycle `fifo_empty_i` rises. Buffered words continue draining.

## Test plan
- **Reset:** hold `rst_i` high with the FIFO non-empty → all outputs at reset values, `fifo_rd_o`=0. Release → first `valid_o` 2 cycles after the first `fifo_rd_o`.
- **Streaming:** FIFO preloaded with 0x0001..0x0040, `ready_i`=1, `PKT_LEN`=16 → 64 words in order at 1 word/cycle after startup. `last_o` on 0x0010, 0x0020, 0x0030, 0x0040. `words_o`=64.
- **Backpressure:** `ready_i`=0 for 10 cycles with the FIFO full → exactly 3 FIFO reads, `occ`=3, `fifo_rd_o`=0 thereafter. Random `ready_i` over 1000 words → scoreboard exact match, no loss or duplication.
- **Enable:** drop `enable_i` one cycle after a `fifo_rd_o` → the in-flight word is still delivered, no further reads, `idle_o`=1 after the buffer drains.
- **Reset mid-burst:** assert `rst_i` with `occ`=2 and `inflight`=1 → `valid_o`=0 and `words_o`=0 immediately. After release, the first delivered word has `pkt_cnt`=0 (with `PKT_LEN`=1, `last_o`=1 on every word).
- **Counter wrap:** preset `words` to 0xFFFFFFFE via force and pop 3 words → `words_o` reads 0xFFFFFFFF, then 0x00000000, then 0x00000001.
